// File: rtl/sio_frame_tx_pkg.sv
// Shared definitions for the serial frame transmitter family.
//   - Default frame width, kept equal to the legacy `WIDTH define (64).
//   - FSM state encoding used by sio_frame_tx.
//   - cnt_width(): counter width helper ($clog2 with a floor of one bit).

`ifndef WIDTH
`define WIDTH 64
`endif

package sio_frame_tx_pkg;

    // Default bits per frame, tied to the legacy global define.
    localparam int SIO_DEFAULT_WIDTH = `WIDTH;

    // Transmitter FSM states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } sio_state_e;

    // Width of a counter that must hold values 0..n-1; never narrower than one bit.
    function automatic int cnt_width(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/sio_frame_tx_shift.sv
// sio_shift_reg: parallel-load / serial-shift register.
// The head bit (MSB or LSB, chosen by MSB_FIRST) is a flop output, so ser_out
// is glitch-free. Each shift moves the next bit into the head position and
// fills the far end with zeros; after WIDTH shifts the register is all zero,
// which is what keeps the serial line low between frames.
// Ports:
//   clk        rising-edge clock
//   clr        synchronous active-high clear
//   load       load load_data (has priority over shift)
//   shift      advance one bit toward the head
//   load_data  parallel word, WIDTH bits
//   ser_out    current head bit
module sio_shift_reg #(
    parameter int WIDTH     = 64,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] load_data,
    output logic             ser_out
);

    logic [WIDTH-1:0] data_r;
    logic [WIDTH-1:0] shifted_s;

    // Shift direction and head position follow the bit order.
    generate
        if (MSB_FIRST) begin : g_msb
            assign shifted_s = {data_r[WIDTH-2:0], 1'b0};
            assign ser_out   = data_r[WIDTH-1];
        end else begin : g_lsb
            assign shifted_s = {1'b0, data_r[WIDTH-1:1]};
            assign ser_out   = data_r[0];
        end
    endgenerate

    // Storage: clear, load, shift or hold.
    always_ff @(posedge clk) begin
        if (clr) begin
            data_r <= {WIDTH{1'b0}};
        end else if (load) begin
            data_r <= load_data;
        end else if (shift) begin
            data_r <= shifted_s;
        end else begin
            data_r <= data_r;
        end
    end

endmodule

// File: rtl/sio_frame_tx.sv
// sio_frame_tx: parallel-to-serial frame transmitter with self-timed enable.
// A word accepted over valid/ready is shifted out on sio while enable is high
// for exactly WIDTH cycles. One further word can wait in a pending register.
// GAP idle cycles (enable low) separate frames; with GAP=0 a pending word
// follows the previous frame with no bubble.
// Ports:
//   clk         rising-edge clock
//   clr         synchronous active-high reset
//   in_valid    producer offers in_data
//   in_ready    block can accept this cycle (low during clr or while pending is full)
//   in_data     parallel word, WIDTH bits, sampled on accept
//   sio         serial data (flop output)
//   enable      frame strobe (flop output)
//   busy        shifting, in gap, or holding a pending word (flop output)
//   frame_done  one-cycle pulse on the last bit of each frame (flop output)
module sio_frame_tx
    import sio_frame_tx_pkg::*;
#(
    parameter int WIDTH     = SIO_DEFAULT_WIDTH,
    parameter bit MSB_FIRST = 1'b1,
    parameter int GAP       = 1
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             sio,
    output logic             enable,
    output logic             busy,
    output logic             frame_done
);

    localparam int BW = cnt_width(WIDTH);
    localparam int GW = cnt_width(GAP + 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
    localparam logic [BW-1:0] BIT_PRE  = BW'(WIDTH - 2);
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP > 0) ? GAP - 1 : 0);
    localparam bit HAS_GAP = (GAP > 0);

    sio_state_e       state_r;
    logic [BW-1:0]    bit_cnt_r;
    logic [GW-1:0]    gap_cnt_r;
    logic [WIDTH-1:0] pend_r;
    logic             pend_v_r;
    logic             enable_r;
    logic             busy_r;
    logic             frame_done_r;

    logic             accept_s;
    logic             bit_last_s;
    logic             gap_last_s;
    logic             sr_load_s;
    logic             sr_shift_s;
    logic [WIDTH-1:0] sr_data_s;
    logic             sio_s;

    // Ready depends only on clr and the pending flag, so it never waits on in_valid.
    assign in_ready   = !clr && !pend_v_r;
    assign accept_s   = in_valid && in_ready;
    assign bit_last_s = (bit_cnt_r == BIT_LAST);
    assign gap_last_s = (gap_cnt_r == GAP_LAST);

    // Shift register control: where the next frame's word comes from, or whether to advance.
    // A word arriving exactly when the line frees up bypasses the pending register.
    always_comb begin
        sr_load_s  = 1'b0;
        sr_shift_s = 1'b0;
        sr_data_s  = pend_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    sr_load_s = 1'b1;
                    sr_data_s = in_data;
                end else begin
                    sr_load_s = 1'b0;
                end
            end
            ST_SHIFT: begin
                if (bit_last_s && !HAS_GAP && pend_v_r) begin
                    sr_load_s = 1'b1;
                end else if (bit_last_s && !HAS_GAP && accept_s) begin
                    sr_load_s = 1'b1;
                    sr_data_s = in_data;
                end else begin
                    // Also the final shift of a frame, which leaves the register zeroed.
                    sr_shift_s = 1'b1;
                end
            end
            ST_GAP: begin
                if (gap_last_s && pend_v_r) begin
                    sr_load_s = 1'b1;
                end else if (gap_last_s && accept_s) begin
                    sr_load_s = 1'b1;
                    sr_data_s = in_data;
                end else begin
                    sr_shift_s = 1'b0;
                end
            end
            default: begin
                sr_load_s = 1'b0;
            end
        endcase
    end

    sio_shift_reg #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_shift (
        .clk       (clk),
        .clr       (clr),
        .load      (sr_load_s),
        .shift     (sr_shift_s),
        .load_data (sr_data_s),
        .ser_out   (sio_s)
    );

    // Frame FSM: state, counters, pending buffer and registered status outputs.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_r      <= ST_IDLE;
            bit_cnt_r    <= {BW{1'b0}};
            gap_cnt_r    <= {GW{1'b0}};
            pend_r       <= {WIDTH{1'b0}};
            pend_v_r     <= 1'b0;
            enable_r     <= 1'b0;
            busy_r       <= 1'b0;
            frame_done_r <= 1'b0;
        end else begin
            frame_done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (sr_load_s) begin
                        state_r   <= ST_SHIFT;
                        bit_cnt_r <= {BW{1'b0}};
                        enable_r  <= 1'b1;
                        busy_r    <= 1'b1;
                    end else begin
                        enable_r  <= 1'b0;
                        busy_r    <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    if (!bit_last_s) begin
                        bit_cnt_r    <= bit_cnt_r + BW'(1);
                        // Registered pulse lands on the cycle that shows the last bit.
                        frame_done_r <= (bit_cnt_r == BIT_PRE);
                        enable_r     <= 1'b1;
                        busy_r       <= 1'b1;
                        if (accept_s) begin
                            pend_r   <= in_data;
                            pend_v_r <= 1'b1;
                        end
                    end else if (sr_load_s) begin
                        // GAP=0: next frame starts immediately, enable stays high.
                        bit_cnt_r <= {BW{1'b0}};
                        pend_v_r  <= 1'b0;
                        enable_r  <= 1'b1;
                        busy_r    <= 1'b1;
                    end else if (HAS_GAP) begin
                        state_r   <= ST_GAP;
                        gap_cnt_r <= {GW{1'b0}};
                        enable_r  <= 1'b0;
                        busy_r    <= 1'b1;
                        if (accept_s) begin
                            pend_r   <= in_data;
                            pend_v_r <= 1'b1;
                        end
                    end else begin
                        state_r  <= ST_IDLE;
                        enable_r <= 1'b0;
                        busy_r   <= 1'b0;
                    end
                end
                ST_GAP: begin
                    if (!gap_last_s) begin
                        gap_cnt_r <= gap_cnt_r + GW'(1);
                        enable_r  <= 1'b0;
                        busy_r    <= 1'b1;
                        if (accept_s) begin
                            pend_r   <= in_data;
                            pend_v_r <= 1'b1;
                        end
                    end else if (sr_load_s) begin
                        state_r   <= ST_SHIFT;
                        bit_cnt_r <= {BW{1'b0}};
                        pend_v_r  <= 1'b0;
                        enable_r  <= 1'b1;
                        busy_r    <= 1'b1;
                    end else begin
                        state_r  <= ST_IDLE;
                        enable_r <= 1'b0;
                        busy_r   <= 1'b0;
                    end
                end
                default: begin
                    // Unreachable encoding: recover to a clean idle line.
                    state_r  <= ST_IDLE;
                    pend_v_r <= 1'b0;
                    enable_r <= 1'b0;
                    busy_r   <= 1'b0;
                end
            endcase
        end
    end

    assign sio        = sio_s;
    assign enable     = enable_r;
    assign busy       = busy_r;
    assign frame_done = frame_done_r;

endmodule
